// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed seven-segment display driver.
// Holds a per-digit buffer of {hex value, decimal point}, scans the digits one
// slot at a time, and applies leading-zero blanking, 16-level PWM brightness
// and output polarity.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wr_en/wr_addr/     buffer write: digit index (0 = rightmost), 5-bit value
//   wr_data/wr_dp      (0x00-0x0F hex glyph, 0x10-0x1F blank), decimal point
//   lzb_en             leading-zero blanking enable
//   brightness         on-time level, 0 = 1/16 .. 15 = 16/16
//   seg                {a,b,c,d,e,f,g,dp}, registered
//   way                one-hot digit select, registered
//   slot_tick          one-cycle pulse on the last cycle of each slot, registered
module seg_scan_mux #(
  parameter int DIGITS          = 4,
  parameter int PRESCALE        = 16384,
  parameter int SEG_ACTIVE_HIGH = 1,
  parameter int DIG_ACTIVE_HIGH = 1,
  localparam int AW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [4:0]        wr_data,
  input  logic              wr_dp,
  input  logic              lzb_en,
  input  logic [3:0]        brightness,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] way,
  output logic              slot_tick
);

  localparam int          PW   = $clog2(PRESCALE);
  localparam int unsigned ND   = DIGITS;
  localparam int unsigned STEP = PRESCALE / 16;
  localparam logic [7:0]        SEG_MASK = (SEG_ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;
  localparam logic [DIGITS-1:0] WAY_MASK = (DIG_ACTIVE_HIGH != 0) ? '0 : '1;

  logic [PW-1:0]     pcnt;
  logic [AW-1:0]     sidx;
  logic [4:0]        buf_val [DIGITS];
  logic              buf_dp  [DIGITS];

  logic              last;
  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] lead;
  logic              lz;
  logic [4:0]        cur_val;
  logic [6:0]        glyph;
  logic [31:0]       on_lim;
  logic              on;
  logic [7:0]        seg_n;
  logic [DIGITS-1:0] way_n;

  assign last = (pcnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      sidx <= '0;
      for (int unsigned i = 0; i < ND; i++) begin
        buf_val[i] <= 5'h10;
        buf_dp[i]  <= 1'b0;
      end
    end else begin
      pcnt <= last ? '0 : pcnt + 1'b1;
      if (last) begin
        sidx <= (sidx == AW'(DIGITS - 1)) ? '0 : sidx + 1'b1;
      end
      if (wr_en && (32'(wr_addr) < ND)) begin
        buf_val[wr_addr] <= wr_data;
        buf_dp[wr_addr]  <= wr_dp;
      end
    end
  end

  // lead[i]: digit i and every digit above it hold 0x0 or blank.
  always_comb begin
    is_zero = '0;
    lead    = '0;
    for (int unsigned k = 0; k < ND; k++) begin
      is_zero[k] = (buf_val[k] == 5'h00) || buf_val[k][4];
    end
    lead[ND-1] = is_zero[ND-1];
    for (int unsigned k = 1; k < ND; k++) begin
      lead[ND-1-k] = is_zero[ND-1-k] & lead[ND-k];
    end
    lz = lzb_en && (sidx != '0) && lead[sidx];
  end

  always_comb begin
    cur_val = buf_val[sidx];
    glyph   = 7'b0000000;
    if (!cur_val[4] && !lz) begin
      unique case (cur_val[3:0])
        4'h0: glyph = 7'b1111110;
        4'h1: glyph = 7'b0110000;
        4'h2: glyph = 7'b1101101;
        4'h3: glyph = 7'b1111001;
        4'h4: glyph = 7'b0110011;
        4'h5: glyph = 7'b1011011;
        4'h6: glyph = 7'b1011111;
        4'h7: glyph = 7'b1110000;
        4'h8: glyph = 7'b1111111;
        4'h9: glyph = 7'b1111011;
        4'hA: glyph = 7'b1110111;
        4'hB: glyph = 7'b0011111;
        4'hC: glyph = 7'b1001110;
        4'hD: glyph = 7'b0111101;
        4'hE: glyph = 7'b1001111;
        4'hF: glyph = 7'b1000111;
        default: glyph = 7'b0000000;
      endcase
    end
    on_lim = (32'(brightness) + 32'd1) * STEP;
    on     = (32'(pcnt) < on_lim);
    seg_n  = '0;
    way_n  = '0;
    if (on) begin
      seg_n = {glyph, buf_dp[sidx]};
      way_n = {{(DIGITS-1){1'b0}}, 1'b1} << sidx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg       <= SEG_MASK;
      way       <= WAY_MASK;
      slot_tick <= 1'b0;
    end else begin
      seg       <= seg_n ^ SEG_MASK;
      way       <= way_n ^ WAY_MASK;
      slot_tick <= last;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [1:0] wr_addr1;
  logic [4:0] wr_data = '0;
  logic       wr_dp = 1'b0;
  logic       lzb_en = 1'b0;
  logic [3:0] brightness = 4'd15;
  logic [7:0] seg0, seg1;
  logic [4:0] way0;
  logic [3:0] way1;
  logic       tick0, tick1;

  assign wr_addr1 = wr_addr[1:0];

  always #5 clk = ~clk;

  seg_scan_mux #(.DIGITS(5), .PRESCALE(16), .SEG_ACTIVE_HIGH(1), .DIG_ACTIVE_HIGH(1)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .lzb_en(lzb_en), .brightness(brightness),
    .seg(seg0), .way(way0), .slot_tick(tick0));

  seg_scan_mux #(.DIGITS(4), .PRESCALE(32), .SEG_ACTIVE_HIGH(0), .DIG_ACTIVE_HIGH(0)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr1), .wr_data(wr_data),
    .wr_dp(wr_dp), .lzb_en(lzb_en), .brightness(brightness),
    .seg(seg1), .way(way1), .slot_tick(tick1));

  // Reference model: per-instance configuration, buffer contents and
  // cycles elapsed since the last reset edge.
  int         D  [2] = '{5, 4};
  int         P  [2] = '{16, 32};
  bit         SH [2] = '{1'b1, 1'b0};
  bit         DH [2] = '{1'b1, 1'b0};
  int         mval [2][16];
  bit         mdp  [2][16];
  int         n = 0;
  bit         valid = 1'b0;
  logic [7:0] GL [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                          8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0] val;
    logic       dp;
    logic [7:0] seg;
  } vec_t;
  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s n=%0d got %h want %h", name, n, act, exp);
    end
  endtask

  // Packed expectation {7'b0, slot_tick, way[15:0], seg[7:0]}.
  function automatic logic [31:0] model_out(input int k);
    int pc, si, v;
    bit blank, on;
    logic [7:0]  s;
    logic [15:0] w, dmask;
    dmask = 16'((32'd1 << D[k]) - 1);
    if (rst) begin
      s = SH[k] ? 8'h00 : 8'hFF;
      w = DH[k] ? 16'h0 : dmask;
      return {7'd0, 1'b0, w, s};
    end
    pc = n % P[k];
    si = (n / P[k]) % D[k];
    on = pc < (int'(brightness) + 1) * (P[k] / 16);
    v  = mval[k][si];
    blank = (v >= 16);
    if (lzb_en && si > 0) begin
      bit all_zero = 1'b1;
      for (int j = si; j < D[k]; j++)
        if (!(mval[k][j] == 0 || mval[k][j] >= 16)) all_zero = 1'b0;
      if (all_zero) blank = 1'b1;
    end
    s = blank ? 8'h00 : GL[v[3:0]];
    s[0] = mdp[k][si];
    w = 16'(1) << si;
    if (!on) begin
      s = 8'h00;
      w = 16'h0;
    end
    if (!SH[k]) s = ~s;
    if (!DH[k]) w = ~w & dmask;
    return {7'd0, pc == P[k] - 1, w, s};
  endfunction

  task automatic tick();
    logic [31:0] e0, e1;
    bit chk;
    chk = rst || valid;
    e0 = model_out(0);
    e1 = model_out(1);
    @(posedge clk);
    if (rst) begin
      n = 0;
      valid = 1'b1;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 16; i++) begin
          mval[k][i] = 16;
          mdp[k][i]  = 1'b0;
        end
    end else begin
      n++;
      if (wr_en) begin
        if (int'(wr_addr) < D[0]) begin
          mval[0][wr_addr] = int'(wr_data);
          mdp[0][wr_addr]  = wr_dp;
        end
        mval[1][wr_addr1] = int'(wr_data);
        mdp[1][wr_addr1]  = wr_dp;
      end
    end
    #1;
    if (chk) begin
      check("model0", {7'd0, tick0, 11'd0, way0, seg0}, e0);
      check("model1", {7'd0, tick1, 12'd0, way1, seg1}, e1);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic write(input int a, input int d, input bit dp);
    wr_en = 1'b1;
    wr_addr = 3'(a);
    wr_data = 5'(d);
    wr_dp = dp;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int cnt, cnt2;
    tbl[0]  = '{5'h00, 1'b0, 8'b11111100};
    tbl[1]  = '{5'h01, 1'b0, 8'b01100000};
    tbl[2]  = '{5'h02, 1'b0, 8'b11011010};
    tbl[3]  = '{5'h03, 1'b0, 8'b11110010};
    tbl[4]  = '{5'h04, 1'b0, 8'b01100110};
    tbl[5]  = '{5'h05, 1'b1, 8'b10110111};
    tbl[6]  = '{5'h06, 1'b0, 8'b10111110};
    tbl[7]  = '{5'h07, 1'b0, 8'b11100000};
    tbl[8]  = '{5'h08, 1'b0, 8'b11111110};
    tbl[9]  = '{5'h09, 1'b0, 8'b11110110};
    tbl[10] = '{5'h0A, 1'b1, 8'b11101111};
    tbl[11] = '{5'h0B, 1'b0, 8'b00111110};
    tbl[12] = '{5'h0C, 1'b0, 8'b10011100};
    tbl[13] = '{5'h0D, 1'b0, 8'b01111010};
    tbl[14] = '{5'h0E, 1'b0, 8'b10011110};
    tbl[15] = '{5'h0F, 1'b0, 8'b10001110};
    tbl[16] = '{5'h10, 1'b0, 8'b00000000};
    tbl[17] = '{5'h1B, 1'b1, 8'b00000001};

    @(negedge clk);
    rst = 1'b1;
    tick();
    check("rst_seg1", {24'd0, seg1}, 32'hFF);
    check("rst_way1", {28'd0, way1}, 32'hF);

    // Glyph table on digit 0 of both instances.
    for (int i = 0; i < 18; i++) begin
      do_reset();
      brightness = 4'd15;
      lzb_en = 1'b0;
      write(0, int'(tbl[i].val), tbl[i].dp);
      tick();
      check("glyph0", {24'd0, seg0}, {24'd0, tbl[i].seg});
      check("glyph1", {24'd0, seg1}, {24'd0, ~tbl[i].seg});
      check("way0_d0", {27'd0, way0}, 32'h01);
      check("way1_d0", {28'd0, way1}, 32'hE);
    end

    // Full scan of 1,2,3,4 with slot_tick pulse counting.
    do_reset();
    for (int i = 0; i < 4; i++) write(i, i + 1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 160; i++) begin
      tick();
      if (tick0) cnt++;
    end
    check("tick_count", cnt, 10);

    // Brightness 3: four lit cycles per slot, dark otherwise.
    brightness = 4'd3;
    cnt = 0;
    cnt2 = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (way0 != '0) cnt++;
      else if (seg0 != 8'h00) cnt2++;
    end
    check("on_cycles", cnt, 20);
    check("off_seg", cnt2, 0);
    brightness = 4'd15;

    // Leading-zero blanking with digits {3..0} = {0,0,7,0}.
    do_reset();
    write(3, 0, 1'b0);
    write(2, 0, 1'b0);
    write(1, 7, 1'b0);
    write(0, 0, 1'b0);
    lzb_en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if ((way0 == 5'b01000 || way0 == 5'b00100) && seg0 != 8'h00) cnt++;
    end
    check("lzb_blank", cnt, 0);
    lzb_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (way0 == 5'b01000 && seg0 == 8'b11111100) cnt++;
    end
    check("lzb_off", cnt, 16);

    // Write to the digit being scanned, mid-slot.
    do_reset();
    write(2, 5, 1'b0);
    while (n % 80 != 40) tick();
    write(2, 10, 1'b1);
    check("wr_old", {24'd0, seg0}, {24'd0, 8'b10110110});
    tick();
    check("wr_new", {24'd0, seg0}, {24'd0, 8'b11101111});
    write(5, 3, 1'b1);
    write(6, 9, 1'b0);
    write(7, 1, 1'b1);
    for (int i = 0; i < 160; i++) tick();

    // Reset mid-slot with a coincident write.
    while (n % 80 != 37) tick();
    rst = 1'b1;
    wr_en = 1'b1;
    wr_addr = 3'd2;
    wr_data = 5'd9;
    wr_dp = 1'b1;
    tick();
    check("mrst_out0", {7'd0, tick0, 16'd0, way0, seg0}, 32'h0);
    check("mrst_out1", {7'd0, tick1, 12'd0, way1, seg1}, {20'd0, 4'hF, 8'hFF});
    rst = 1'b0;
    wr_en = 1'b0;
    tick();
    check("post_rst_way", {27'd0, way0}, 32'h01);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (seg0 != 8'h00) cnt++;
    end
    check("post_rst_blank", cnt, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      wr_en = ($urandom_range(3) == 0);
      wr_addr = 3'($urandom_range(7));
      wr_data = ($urandom_range(2) == 0) ? 5'd0 : 5'($urandom_range(31));
      wr_dp = 1'($urandom_range(1));
      if ($urandom_range(49) == 0) lzb_en = ~lzb_en;
      if ($urandom_range(29) == 0) brightness = 4'($urandom_range(15));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
